seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/seg7_scan.sv | 119 +++++++++++
 tb/tb_seg7_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the three-digit multiplexed seven-segment scanner.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    localparam logic [6:0] GLYPH_0    = 7'h40;
    localparam logic [6:0] GLYPH_1    = 7'h79;
    localparam logic [6:0] GLYPH_2    = 7'h24;
    localparam logic [6:0] GLYPH_3    = 7'h30;
    localparam logic [6:0] GLYPH_4    = 7'h19;
    localparam logic [6:0] GLYPH_5    = 7'h12;
    localparam logic [6:0] GLYPH_6    = 7'h02;
    localparam logic [6:0] GLYPH_7    = 7'h78;
    localparam logic [6:0] GLYPH_8    = 7'h00;
    localparam logic [6:0] GLYPH_9    = 7'h10;
    localparam logic [6:0] GLYPH_DASH = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Purely combinational BCD nibble to active-low seven-segment glyph decoder.
// Non-decimal nibbles (10-15) render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        seg = GLYPH_DASH;
        case (digit)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Three-digit multiplexed seven-segment scanner with ghost-suppression gap,
// frame-synchronous display update and optional leading-zero blanking.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_CYCLES = 1000,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned   CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYCLES);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   display_q, display_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digit_sel;
    logic          digit_dark;
    logic [3:0]    an_sel;
    logic [6:0]    glyph;

    always_comb begin
        slot_end     = (count_q == CNT_MAX);
        frame_end    = slot_end && (state_q == DIG2);
        count_d      = slot_end ? '0 : count_q + CW'(1);
        state_d      = state_q;
        if (slot_end) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                default: state_d = DIG0;
            endcase
        end
        shadow_d     = load ? bcd_in : shadow_q;
        // A load coinciding with the frame boundary bypasses the shadow so it is not lost for a frame.
        display_d    = frame_end ? shadow_d : display_q;
        frame_tick_d = frame_end;
    end

    // Outputs are decoded from next-state so the registered an/seg line up with count_q/state_q.
    always_comb begin
        digit_sel  = display_q[3:0];
        digit_dark = 1'b0;
        an_sel     = 4'b1110;
        case (state_d)
            DIG1: begin
                digit_sel  = display_q[7:4];
                digit_dark = BLANK_LZ && (display_q[11:4] == 8'h00);
                an_sel     = 4'b1101;
            end
            DIG2: begin
                digit_sel  = display_q[11:8];
                digit_dark = BLANK_LZ && (display_q[11:8] == 4'h0);
                an_sel     = 4'b1011;
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_decoder (
        .digit (digit_sel),
        .seg   (glyph)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (!blank && (count_d >= CNT_GHOST) && !digit_dark) begin
            an_d  = an_sel;
            seg_d = glyph;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: shadow and display are small registers, not memories, and are reset so the first frame shows "  0".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DIG0;
            count_q      <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=8, GHOST_CYCLES=2, BLANK_LZ=1.
// cyc counts rising edges since reset release, so count = cyc%8 and slot = (cyc/8)%3.
module tb_seg7_scan;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        load;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int blank_lo = -1;
    int blank_hi = -1;

    seg7_scan #(
        .REFRESH_DIV  (8),
        .GHOST_CYCLES (2),
        .BLANK_LZ     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
    endtask

    // Checks one 8-cycle slot starting at count 0; optionally presents a load at count load_cnt.
    task automatic check_slot(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                              input int load_cnt, input logic [11:0] load_val);
        for (int c = 0; c < 8; c++) begin
            logic dark;
            logic exp_ft;
            dark   = (c < 2) || (cyc >= blank_lo && cyc <= blank_hi);
            exp_ft = (cyc % 24 == 0) && (cyc != 0);
            check({tag, "_an"},  12'(an),         dark ? 12'hF  : 12'(exp_an));
            check({tag, "_seg"}, 12'(seg),        dark ? 12'h7F : 12'(exp_seg));
            check({tag, "_ft"},  12'(frame_tick), 12'(exp_ft));
            if (c == load_cnt) begin
                bcd_in = load_val;
                load   = 1'b1;
            end
            blank = (cyc + 1 >= blank_lo) && (cyc + 1 <= blank_hi);
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        bcd_in = 12'h000;
        load   = 1'b0;
        blank  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_an",  12'(an),         12'hF);
        check("rst_seg", 12'(seg),        12'h7F);
        check("rst_dp",  12'(dp),         12'h1);
        check("rst_ft",  12'(frame_tick), 12'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;

        // Frame 0: reset contents "  0"; load 123 early.
        check_slot("f0_d0", 4'b1110, 7'h40, 0, 12'h123);
        check_slot("f0_d1", 4'b1111, 7'h7F, -1, 12'h000);
        check_slot("f0_d2", 4'b1111, 7'h7F, -1, 12'h000);

        // Frame 1: 123; load 007.
        check_slot("f1_d0", 4'b1110, 7'h30, 0, 12'h007);
        check_slot("f1_d1", 4'b1101, 7'h24, -1, 12'h000);
        check_slot("f1_d2", 4'b1011, 7'h79, -1, 12'h000);

        // Frame 2: 007 with leading zeros dark; load 000.
        check_slot("f2_d0", 4'b1110, 7'h78, 0, 12'h000);
        check_slot("f2_d1", 4'b1111, 7'h7F, -1, 12'h000);
        check_slot("f2_d2", 4'b1111, 7'h7F, -1, 12'h000);

        // Frame 3: 000; 456 mid-DIG1, then 789 on the frame-end cycle.
        check_slot("f3_d0", 4'b1110, 7'h40, -1, 12'h000);
        check_slot("f3_d1", 4'b1111, 7'h7F, 1, 12'h456);
        check_slot("f3_d2", 4'b1111, 7'h7F, 7, 12'h789);

        // Frame 4: 789 via bypass; load 1A5.
        check_slot("f4_d0", 4'b1110, 7'h10, 0, 12'h1A5);
        check_slot("f4_d1", 4'b1101, 7'h00, -1, 12'h000);
        check_slot("f4_d2", 4'b1011, 7'h78, -1, 12'h000);

        // Frame 5: 1A5, tens shows a dash.
        check_slot("f5_d0", 4'b1110, 7'h12, -1, 12'h000);
        check_slot("f5_d1", 4'b1101, 7'h3F, -1, 12'h000);
        check_slot("f5_d2", 4'b1011, 7'h79, -1, 12'h000);

        // Frame 6: blank held for edges 156..165, starting mid-DIG1.
        blank_lo = 156;
        blank_hi = 165;
        check_slot("f6_d0", 4'b1110, 7'h12, -1, 12'h000);
        check_slot("f6_d1", 4'b1101, 7'h3F, -1, 12'h000);
        check_slot("f6_d2", 4'b1011, 7'h79, -1, 12'h000);
        blank_lo = -1;
        blank_hi = -1;

        // Frame 7: reset asserted at DIG2 count 5.
        check_slot("f7_d0", 4'b1110, 7'h12, -1, 12'h000);
        check_slot("f7_d1", 4'b1101, 7'h3F, -1, 12'h000);
        for (int k = 0; k < 5; k++) tick();
        check("f7_pre_rst_an",  12'(an),  12'hB);
        check("f7_pre_rst_seg", 12'(seg), 12'h79);
        rst_n = 1'b0;
        #1;
        check("mid_rst_an",  12'(an),         12'hF);
        check("mid_rst_seg", 12'(seg),        12'h7F);
        check("mid_rst_dp",  12'(dp),         12'h1);
        check("mid_rst_ft",  12'(frame_tick), 12'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;

        check_slot("r_d0", 4'b1110, 7'h40, -1, 12'h000);
        check_slot("r_d1", 4'b1111, 7'h7F, -1, 12'h000);
        check_slot("r_d2", 4'b1111, 7'h7F, -1, 12'h000);
        check("r_ft", 12'(frame_tick), 12'h1);
        check("r_dp", 12'(dp),         12'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
